rom_arb: RTL and testbench

ROM_ARB -- requirements
Module: rom_arb

---
 rtl/rom_arb.sv | 81 ++++++++
 tb/tb_rom_arb.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/rom_arb.sv
// Two-requester ROM arbiter: core fetch port and debug/loader port share one
// single-cycle-latency ROM; debug wins after WAIT_MAX consecutive lost cycles.
module rom_arb #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned WAIT_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic [ADDR_W-1:0] core_addr,
  output logic              core_gnt,
  output logic              core_stall,
  output logic              core_valid,
  output logic [DATA_W-1:0] core_data,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic              dbg_halt,
  output logic              dbg_gnt,
  output logic              dbg_valid,
  output logic [DATA_W-1:0] dbg_data,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_data_i
);

  localparam logic [3:0] WAIT_LIM = 4'(WAIT_MAX);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RESP_CORE = 2'd1,
    RESP_DBG  = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] wait_cnt;
  logic       core_elig;
  logic       dbg_win;

  // Grants are forced low while reset is held so every output reads 0.
  always_comb begin
    core_elig  = core_req && !dbg_halt;
    dbg_win    = dbg_req && (!core_elig || (wait_cnt == WAIT_LIM));
    dbg_gnt    = rst && dbg_win;
    core_gnt   = rst && core_elig && !dbg_win;
    core_stall = rst && core_req && !core_gnt;
    rom_ce_o   = core_gnt || dbg_gnt;
    rom_addr_o = '0;
    if (core_gnt)
      rom_addr_o = core_addr;
    else if (dbg_gnt)
      rom_addr_o = dbg_addr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      if (core_gnt)
        state <= RESP_CORE;
      else if (dbg_gnt)
        state <= RESP_DBG;
      else
        state <= IDLE;

      if (dbg_req && !dbg_gnt)
        wait_cnt <= (wait_cnt == WAIT_LIM) ? wait_cnt : wait_cnt + 4'd1;
      else
        wait_cnt <= '0;
    end
  end

  always_comb begin
    core_valid = (state == RESP_CORE);
    dbg_valid  = (state == RESP_DBG);
    core_data  = core_valid ? rom_data_i : '0;
    dbg_data   = dbg_valid  ? rom_data_i : '0;
  end

endmodule

// File: tb/tb_rom_arb.sv
// Directed bench for rom_arb: per-cycle vector table plus hand-written
// reset-during-response and repeating-contention sequences.
module tb_rom_arb;

  localparam logic [31:0] DA = 32'h0000_0200;
  localparam logic [31:0] FD = 32'h0000_1600;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, dbg_req, dbg_halt;
  logic [31:0] core_addr, dbg_addr;
  logic        core_gnt, core_stall, core_valid;
  logic [31:0] core_data;
  logic        dbg_gnt, dbg_valid;
  logic [31:0] dbg_data;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_q = '0;

  int checks = 0;
  int errors = 0;

  rom_arb #(.ADDR_W(32), .DATA_W(32), .WAIT_MAX(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .core_req   (core_req),
    .core_addr  (core_addr),
    .core_gnt   (core_gnt),
    .core_stall (core_stall),
    .core_valid (core_valid),
    .core_data  (core_data),
    .dbg_req    (dbg_req),
    .dbg_addr   (dbg_addr),
    .dbg_halt   (dbg_halt),
    .dbg_gnt    (dbg_gnt),
    .dbg_valid  (dbg_valid),
    .dbg_data   (dbg_data),
    .rom_ce_o   (rom_ce_o),
    .rom_addr_o (rom_addr_o),
    .rom_data_i (rom_q)
  );

  always #5 clk = ~clk;

  // ROM contents: word at address a holds a*3 + 0x1000
  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    return a * 32'd3 + 32'h0000_1000;
  endfunction

  always @(posedge clk)
    if (rom_ce_o) rom_q <= rom_fn(rom_addr_o);

  typedef struct {
    logic        r, creq;
    logic [31:0] ca;
    logic        dreq;
    logic [31:0] da;
    logic        h;
    logic        cg, cs, dg;
    logic [31:0] ra;
    logic        cv;
    logic [31:0] cd;
    logic        dv;
    logic [31:0] dd;
  } vec_t;

  function automatic vec_t v(input logic r, input logic creq, input logic [31:0] ca,
                             input logic dreq, input logic [31:0] da, input logic h,
                             input logic cg, input logic cs, input logic dg,
                             input logic [31:0] ra, input logic cv, input logic [31:0] cd,
                             input logic dv, input logic [31:0] dd);
    vec_t t;
    t.r = r; t.creq = creq; t.ca = ca; t.dreq = dreq; t.da = da; t.h = h;
    t.cg = cg; t.cs = cs; t.dg = dg; t.ra = ra;
    t.cv = cv; t.cd = cd; t.dv = dv; t.dd = dd;
    return t;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got 0x%08h, expected 0x%08h", name, idx, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic creq, input logic [31:0] ca,
                       input logic dreq, input logic [31:0] da, input logic h);
    rst = r; core_req = creq; core_addr = ca; dbg_req = dreq; dbg_addr = da; dbg_halt = h;
  endtask

  vec_t vecs[$];

  initial begin
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);

    //        r  creq ca     dreq da  h   cg cs dg ra     cv cd            dv dd
    vecs.push_back(v(0, 1, 32'h10, 1, DA, 0,  0, 0, 0, 32'h0,  0, 32'h0,    0, 32'h0));
    vecs.push_back(v(1, 1, 32'h0,  0, 0,  0,  1, 0, 0, 32'h0,  0, 32'h0,    0, 32'h0));
    vecs.push_back(v(1, 1, 32'h4,  0, 0,  0,  1, 0, 0, 32'h4,  1, 32'h1000, 0, 32'h0));
    vecs.push_back(v(1, 1, 32'h8,  0, 0,  0,  1, 0, 0, 32'h8,  1, 32'h100C, 0, 32'h0));
    vecs.push_back(v(1, 0, 32'h0,  0, 0,  0,  0, 0, 0, 32'h0,  1, 32'h1018, 0, 32'h0));
    vecs.push_back(v(1, 0, 32'h0,  0, 0,  0,  0, 0, 0, 32'h0,  0, 32'h0,    0, 32'h0));
    vecs.push_back(v(1, 1, 32'h20, 0, 0,  1,  0, 1, 0, 32'h0,  0, 32'h0,    0, 32'h0));
    vecs.push_back(v(1, 1, 32'h20, 0, 0,  0,  1, 0, 0, 32'h20, 0, 32'h0,    0, 32'h0));
    vecs.push_back(v(1, 0, 32'h0,  0, 0,  0,  0, 0, 0, 32'h0,  1, 32'h1060, 0, 32'h0));
    vecs.push_back(v(1, 1, 32'h30, 1, DA, 0,  1, 0, 0, 32'h30, 0, 32'h0,    0, 32'h0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(v(1, 1, 32'h30, 1, DA, 0, 1, 0, 0, 32'h30, 1, 32'h1090, 0, 32'h0));
    vecs.push_back(v(1, 1, 32'h30, 1, DA, 0,  0, 1, 1, DA,     1, 32'h1090, 0, 32'h0));
    vecs.push_back(v(1, 1, 32'h30, 1, DA, 0,  1, 0, 0, 32'h30, 0, 32'h0,    1, FD));
    vecs.push_back(v(1, 0, 32'h0,  0, 0,  0,  0, 0, 0, 32'h0,  1, 32'h1090, 0, 32'h0));
    // two cycles of debug pressure, then dropped: count must restart from 0
    vecs.push_back(v(1, 1, 32'h30, 1, DA, 0,  1, 0, 0, 32'h30, 0, 32'h0,    0, 32'h0));
    vecs.push_back(v(1, 1, 32'h30, 1, DA, 0,  1, 0, 0, 32'h30, 1, 32'h1090, 0, 32'h0));
    vecs.push_back(v(1, 1, 32'h30, 0, 0,  0,  1, 0, 0, 32'h30, 1, 32'h1090, 0, 32'h0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(v(1, 1, 32'h30, 1, DA, 0, 1, 0, 0, 32'h30, 1, 32'h1090, 0, 32'h0));
    vecs.push_back(v(1, 1, 32'h30, 1, DA, 0,  0, 1, 1, DA,     1, 32'h1090, 0, 32'h0));
    vecs.push_back(v(1, 0, 32'h0,  0, 0,  0,  0, 0, 0, 32'h0,  0, 32'h0,    1, FD));
    vecs.push_back(v(1, 0, 32'h0,  0, 0,  0,  0, 0, 0, 32'h0,  0, 32'h0,    0, 32'h0));
    vecs.push_back(v(1, 0, 32'h0,  1, DA, 0,  0, 0, 1, DA,     0, 32'h0,    0, 32'h0));
    vecs.push_back(v(1, 0, 32'h0,  0, 0,  0,  0, 0, 0, 32'h0,  0, 32'h0,    1, FD));
    vecs.push_back(v(1, 1, 32'h30, 1, DA, 1,  0, 1, 1, DA,     0, 32'h0,    0, 32'h0));
    vecs.push_back(v(1, 0, 32'h0,  0, 0,  0,  0, 0, 0, 32'h0,  0, 32'h0,    1, FD));
    // halt rising while a core response is in flight
    vecs.push_back(v(1, 1, 32'h10, 0, 0,  0,  1, 0, 0, 32'h10, 0, 32'h0,    0, 32'h0));
    vecs.push_back(v(1, 1, 32'h10, 0, 0,  1,  0, 1, 0, 32'h0,  1, 32'h1030, 0, 32'h0));
    vecs.push_back(v(1, 0, 32'h0,  0, 0,  0,  0, 0, 0, 32'h0,  0, 32'h0,    0, 32'h0));

    @(posedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i].r, vecs[i].creq, vecs[i].ca, vecs[i].dreq, vecs[i].da, vecs[i].h);
      #3;
      check("core_gnt",   i, 32'(core_gnt),   32'(vecs[i].cg));
      check("core_stall", i, 32'(core_stall), 32'(vecs[i].cs));
      check("dbg_gnt",    i, 32'(dbg_gnt),    32'(vecs[i].dg));
      check("rom_ce_o",   i, 32'(rom_ce_o),   32'(vecs[i].cg | vecs[i].dg));
      check("rom_addr_o", i, rom_addr_o,      vecs[i].ra);
      check("core_valid", i, 32'(core_valid), 32'(vecs[i].cv));
      check("core_data",  i, core_data,       vecs[i].cd);
      check("dbg_valid",  i, 32'(dbg_valid),  32'(vecs[i].dv));
      check("dbg_data",   i, dbg_data,        vecs[i].dd);
    end

    // Reset pulled the cycle after a core grant at 0x10: the response is lost.
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 32'h10, 1'b0, '0, 1'b0);
    #3 check("rst_seq_gnt", 0, 32'(core_gnt), 32'd1);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 32'h10, 1'b1, DA, 1'b0);
    #3;
    check("rst_seq_cvalid", 1, 32'(core_valid), 32'd0);
    check("rst_seq_cdata",  1, core_data,       32'd0);
    check("rst_seq_ce",     1, 32'(rom_ce_o),   32'd0);
    check("rst_seq_addr",   1, rom_addr_o,      32'd0);
    check("rst_seq_grants", 1, 32'({core_gnt, dbg_gnt, core_stall}), 32'd0);
    for (int i = 2; i < 4; i++) begin
      @(posedge clk); #1;
      drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
      #3;
      check("rst_rel_cvalid", i, 32'(core_valid), 32'd0);
      check("rst_rel_dvalid", i, 32'(dbg_valid),  32'd0);
      check("rst_rel_ce",     i, 32'(rom_ce_o),   32'd0);
    end

    // Continuous contention from a cleared count: C,C,C,C,D repeating.
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      drive(1'b1, 1'b1, 32'h40, 1'b1, DA, 1'b0);
      #3;
      check("pat_dbg_gnt",   i, 32'(dbg_gnt),   32'((i % 5) == 4));
      check("pat_core_gnt",  i, 32'(core_gnt),  32'((i % 5) != 4));
      check("pat_dbg_valid", i, 32'(dbg_valid), 32'((i % 5) == 0 && i != 0));
      if ((i % 5) == 0 && i != 0)
        check("pat_dbg_data", i, dbg_data, FD);
    end

    @(posedge clk); #1;
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
